// File: rtl/ibm_sched.sv
// ibm_sched: sequences syndrome sets through the ibm key-equation solver toward Chien search.
// Define IBM_SCHED_WATCHDOG_EN to abort solver jobs that exceed WDOG_LIMIT wait cycles.
module ibm_sched #(
  parameter int unsigned SYM_W      = 10,
  parameter int unsigned NSYND      = 8,
  parameter int unsigned NSIG       = 8,
  parameter int unsigned WDOG_LIMIT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic                   i_s_mode,
  input  logic [1:0]             i_s_code,
  input  logic [NSYND*SYM_W-1:0] i_s_synd,
  output logic                   o_ibm_clear_and_wen,
  output logic                   o_ibm_mode,
  output logic [1:0]             o_ibm_code,
  output logic [NSYND*SYM_W-1:0] o_ibm_synd,
  input  logic                   i_ibm_valid,
  input  logic [NSIG*SYM_W-1:0]  i_ibm_sigma,
  output logic                   o_sig_valid,
  input  logic                   i_sig_ready,
  output logic [NSIG*SYM_W-1:0]  o_sigma,
  output logic [1:0]             o_sig_code,
  output logic                   o_sig_mode,
  output logic                   o_sig_zero,
  output logic                   o_sig_fail,
  output logic                   o_busy,
  output logic [15:0]            o_blk_cnt
);

  localparam int unsigned SYND_W = NSYND * SYM_W;
  localparam int unsigned SIG_W  = NSIG * SYM_W;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;

  logic                pend_v_q, pend_v_d;
  logic                pend_zero_q, pend_zero_d;
  logic                pend_mode_q, pend_mode_d;
  logic [CODE_W-1:0]   pend_code_q, pend_code_d;
  logic [SYND_W-1:0]   pend_synd_q, pend_synd_d;

  logic                job_mode_q, job_mode_d;
  logic [CODE_W-1:0]   job_code_q, job_code_d;

  logic                sig_valid_q, sig_valid_d;
  logic [SIG_W-1:0]    sigma_q, sigma_d;
  logic [CODE_W-1:0]   sig_code_q, sig_code_d;
  logic                sig_mode_q, sig_mode_d;
  logic                sig_zero_q, sig_zero_d;
  logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;

  logic                out_free_c;
  logic                accept_c;
  logic                launch_c;
  logic                sig_hs_c;

`ifdef IBM_SCHED_WATCHDOG_EN
  localparam int unsigned WDOG_W = 4;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                sig_fail_q, sig_fail_d;
`else
  logic                unused_wdog;
  assign unused_wdog = (WDOG_LIMIT == 0);
`endif

  assign out_free_c = ~sig_valid_q | i_sig_ready;
  assign accept_c   = i_s_valid & ~pend_v_q;
  assign sig_hs_c   = sig_valid_q & i_sig_ready;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pend_v_q    <= 1'b0;
      pend_zero_q <= 1'b0;
      pend_mode_q <= 1'b0;
      pend_code_q <= '0;
      pend_synd_q <= '0;
      job_mode_q  <= 1'b0;
      job_code_q  <= '0;
      sig_valid_q <= 1'b0;
      sigma_q     <= '0;
      sig_code_q  <= '0;
      sig_mode_q  <= 1'b0;
      sig_zero_q  <= 1'b0;
      blk_cnt_q   <= '0;
`ifdef IBM_SCHED_WATCHDOG_EN
      wdog_q      <= '0;
      sig_fail_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_zero_q <= pend_zero_d;
      pend_mode_q <= pend_mode_d;
      pend_code_q <= pend_code_d;
      pend_synd_q <= pend_synd_d;
      job_mode_q  <= job_mode_d;
      job_code_q  <= job_code_d;
      sig_valid_q <= sig_valid_d;
      sigma_q     <= sigma_d;
      sig_code_q  <= sig_code_d;
      sig_mode_q  <= sig_mode_d;
      sig_zero_q  <= sig_zero_d;
      blk_cnt_q   <= blk_cnt_d;
`ifdef IBM_SCHED_WATCHDOG_EN
      wdog_q      <= wdog_d;
      sig_fail_q  <= sig_fail_d;
`endif
    end
  end

  // Next-state: dispatch pending set, capture solver result, accept new set
  always_comb begin
    state_d     = state_q;
    pend_v_d    = pend_v_q;
    pend_zero_d = pend_zero_q;
    pend_mode_d = pend_mode_q;
    pend_code_d = pend_code_q;
    pend_synd_d = pend_synd_q;
    job_mode_d  = job_mode_q;
    job_code_d  = job_code_q;
    sig_valid_d = sig_valid_q & ~i_sig_ready;
    sigma_d     = sigma_q;
    sig_code_d  = sig_code_q;
    sig_mode_d  = sig_mode_q;
    sig_zero_d  = sig_zero_q;
    blk_cnt_d   = blk_cnt_q + CNT_W'(sig_hs_c);
    launch_c    = 1'b0;
`ifdef IBM_SCHED_WATCHDOG_EN
    wdog_d      = wdog_q;
    sig_fail_d  = sig_fail_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_v_q && out_free_c) begin
          pend_v_d = 1'b0;
          if (pend_zero_q) begin
            // All-zero syndromes mean no errors: answer without the solver
            sig_valid_d = 1'b1;
            sigma_d     = '0;
            sig_code_d  = pend_code_q;
            sig_mode_d  = pend_mode_q;
            sig_zero_d  = 1'b1;
`ifdef IBM_SCHED_WATCHDOG_EN
            sig_fail_d  = 1'b0;
`endif
          end else begin
            launch_c   = 1'b1;
            job_code_d = pend_code_q;
            job_mode_d = pend_mode_q;
            state_d    = ST_WAIT;
`ifdef IBM_SCHED_WATCHDOG_EN
            wdog_d     = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (i_ibm_valid) begin
          sig_valid_d = 1'b1;
          sigma_d     = i_ibm_sigma;
          sig_code_d  = job_code_q;
          sig_mode_d  = job_mode_q;
          sig_zero_d  = 1'b0;
          state_d     = ST_IDLE;
`ifdef IBM_SCHED_WATCHDOG_EN
          sig_fail_d  = 1'b0;
        end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
          // Solver never answered: release downstream with a failed result
          sig_valid_d = 1'b1;
          sigma_d     = '0;
          sig_code_d  = job_code_q;
          sig_mode_d  = job_mode_q;
          sig_zero_d  = 1'b0;
          sig_fail_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) begin
      pend_v_d    = 1'b1;
      pend_synd_d = i_s_synd;
      pend_code_d = i_s_code;
      pend_mode_d = i_s_mode;
      pend_zero_d = (i_s_synd == '0);
    end
  end

  assign o_s_ready           = ~pend_v_q & ~i_rst;
  assign o_ibm_clear_and_wen = launch_c & ~i_rst;
  // Launch cycle drives the pending job; afterwards the launched job stays on the bus
  assign o_ibm_code          = o_ibm_clear_and_wen ? pend_code_q : job_code_q;
  assign o_ibm_mode          = o_ibm_clear_and_wen ? pend_mode_q : job_mode_q;
  assign o_ibm_synd          = pend_synd_q;
  assign o_sig_valid         = sig_valid_q;
  assign o_sigma             = sigma_q;
  assign o_sig_code          = sig_code_q;
  assign o_sig_mode          = sig_mode_q;
  assign o_sig_zero          = sig_zero_q;
  assign o_busy              = (state_q != ST_IDLE) | pend_v_q | sig_valid_q;
  assign o_blk_cnt           = blk_cnt_q;
`ifdef IBM_SCHED_WATCHDOG_EN
  assign o_sig_fail          = sig_fail_q;
`else
  assign o_sig_fail          = 1'b0;
`endif

endmodule

// File: doc/ibm_sched.md
Name: ibm_sched

Overview:
- Job sequencer in front of the ibm key-equation solver.
- Accepts syndrome sets from the syndrome stage over valid/ready and buffers one pending set.
- Launches the solver with a one-cycle clear/write pulse and holds code/mode stable while it runs.
- Captures sigma coefficients on the solver's valid, then presents them to the Chien-search stage over valid/ready. All-zero syndrome sets bypass the solver.

Parameters:
SYM_W, 10, GF symbol width
NSYND, 8, syndromes per set (S1 at LSBs)
NSIG, 8, sigma coefficients (sigma1_0..4, sigma2_0..2, sigma1_0 at LSBs)
WDOG_LIMIT, 15, watchdog cycles in WAIT (optional feature only)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_s_valid  in  1  syndrome set valid
o_s_ready  out  1  pending buffer empty
i_s_mode  in  1  0 single, 1 double
i_s_code  in  2  code select (2'b10 = long code)
i_s_synd  in  NSYND*SYM_W  syndromes
o_ibm_clear_and_wen  out  1  solver launch pulse
o_ibm_mode  out  1  held mode
o_ibm_code  out  2  held code
o_ibm_synd  out  NSYND*SYM_W  syndromes, valid with launch pulse
i_ibm_valid  in  1  solver result valid (1-cycle pulse)
i_ibm_sigma  in  NSIG*SYM_W  solver coefficients
o_sig_valid  out  1  result valid
i_sig_ready  in  1  downstream accepts
o_sigma  out  NSIG*SYM_W  captured coefficients
o_sig_code  out  2  code of result
o_sig_mode  out  1  mode of result
o_sig_zero  out  1  set was all-zero (no errors)
o_sig_fail  out  1  watchdog abort (0 when feature off)
o_busy  out  1  state != IDLE or pending or output valid
o_blk_cnt  out  16  results delivered, wraps at 16'hFFFF->0

Behaviour:
- Reset: every register cleared. All outputs 0, including o_s_ready = 0 during the reset cycle and o_ibm_code = 2'b00. o_s_ready = 1 from the first cycle after reset. Reset mid-job aborts it silently: no output and no count. The solver has its own reset.
- Pending buffer: one entry. o_s_ready = !pend_v. Accept on i_s_valid & o_s_ready; syndromes, code and mode are latched. pend_zero = (syndrome bus == 0), registered at accept.
- Output slot: one register. out_free = !o_sig_valid | i_sig_ready.
- FSM states: IDLE, WAIT.
- IDLE, pend_v & out_free & pend_zero:
  - Load output with sigma = 0, zero = 1, code/mode from pending.
  - Clear pend_v. Stay in IDLE. No launch.
- IDLE, pend_v & out_free & !pend_zero:
  - Assert o_ibm_clear_and_wen for exactly this cycle, with o_ibm_synd, o_ibm_code and o_ibm_mode from pending.
  - Clear pend_v. Go to WAIT.
- WAIT:
  - o_ibm_clear_and_wen = 0.
  - o_ibm_code and o_ibm_mode held at the launched job's values until the cycle after capture.
  - On i_ibm_valid: o_sigma <= i_ibm_sigma, zero = 0, o_sig_valid <= 1. Go to IDLE.
  - Launch rule guarantees the output slot is free at capture; i_ibm_valid outside WAIT is ignored.
- Nominal solver latency: launch at cycle T gives valid at T+8 (code 2'b10) or T+4 (other codes). The scheduler does not count it; it relies on i_ibm_valid.
- Output handshake: o_sig_valid drops on i_sig_ready unless a new result loads in the same cycle. Data stable while valid & !ready.
- o_blk_cnt increments on each o_sig_valid & i_sig_ready.
- Simultaneous events:
  - Input accept and pending consume never coincide, since ready is from pend_v.
  - Output accept and new load in the same cycle: the load wins and valid stays 1.
- Throughput: one set per solver latency + 1 cycle. A back-to-back input is held in pending during WAIT.

Optional Feature:
- IBM_SCHED_WATCHDOG_EN defined:
  - 4-bit counter cleared on launch, incremented each WAIT cycle.
  - On reaching WDOG_LIMIT without i_ibm_valid: load output with sigma = 0, fail = 1, zero = 0. Go to IDLE.
  - i_ibm_valid in the same cycle as expiry takes priority and the result is normal.
- Undefined: no counter; WAIT lasts indefinitely; o_sig_fail tied 0.

Test Plan:
- Reset, then code 2'b00 set with S1 = 10'h001, others 0 -> launch pulse 1 cycle after accept. Model returns sigma 80'h...0ABC at T+4 -> o_sig_valid with that value, zero = 0, o_blk_cnt = 1.
- All-zero set, code 2'b10 -> no launch pulse; o_sig_valid 2 cycles after accept with sigma = 0, zero = 1, code = 2'b10.
- Two non-zero sets back-to-back, code 2'b10, i_sig_ready = 1 -> second launch the cycle after first capture. o_ibm_code stays 2'b10 throughout; two results in order; o_blk_cnt = 2.
- i_sig_ready = 0 with a result held, plus a new non-zero set -> no launch until ready rises. o_sigma unchanged while stalled; third set sees o_s_ready = 0.
- Reset asserted in WAIT, then solver valid pulses -> o_sig_valid stays 0, o_blk_cnt = 0, o_s_ready = 1 after reset.
- Watchdog on, solver never responds -> o_sig_valid with fail = 1, sigma = 0 at launch + 15 WAIT cycles; scheduler accepts the next set.
